dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 core_req  input  1  core requests a memory access.
REQ-006 core_we  input  1  core access type: 1 write, 0 read.
REQ-007 core_addr  input  ADDR_W  core word address.
REQ-008 core_wdata  input  DATA_W  core write data.
REQ-009 core_ack  output  1  one-cycle pulse: core access complete.
REQ-010 core_rdata  output  DATA_W  core read data, valid while core_ack=1.
REQ-011 dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata: same directions, widths and meanings as the core_* ports, for the DMA requester.
REQ-012 mem_addr  output  ADDR_W  address to data memory.
REQ-013 mem_wdata  output  DATA_W  write data to data memory.
REQ-014 mem_we  output  1  data-memory write enable.
REQ-015 mem_rdata  input  DATA_W  data-memory read data, valid one cycle after mem_addr is presented.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states are exactly IDLE, ACCESS and RESP.
REQ-018 In IDLE with no request, the FSM stays in IDLE; mem_we=0.
REQ-019 In IDLE with exactly one request, that requester is granted and the FSM moves to ACCESS.
REQ-020 In IDLE with both requests, grant goes to the requester not granted last (round-robin, last_grant register); last_grant updates on every grant.
REQ-021 On grant, the winner's we/addr/wdata are registered; mem_addr/mem_wdata/mem_we are driven only from these registers, never combinationally from requester inputs.
REQ-022 In ACCESS (exactly 1 cycle), mem_we equals the registered we; the FSM then moves to RESP.
REQ-023 In RESP (exactly 1 cycle), mem_we=0, the granted requester's ack=1, and its rdata=mem_rdata for a read or 0 for a write; the FSM then returns to IDLE.
REQ-024 Latency: request sampled in IDLE at edge N; ACCESS during cycle N+1; ack during cycle N+2; an access occupies 3 cycles including IDLE.
REQ-025 Requesters hold req/we/addr/wdata stable until ack; req still high in the cycle after ack is a new request.
REQ-026 The non-granted requester's ack stays 0 and its rdata stays 0; its pending req is arbitrated at the next IDLE.
REQ-027 Under continuous contention, grants strictly alternate core, dma, core, ...; neither requester waits more than one access.
REQ-028 Requests arriving in ACCESS or RESP are ignored until IDLE; at most one ack is high in any cycle.
REQ-029 mem_addr and mem_wdata hold their last values in IDLE; only mem_we gates writes.

Reset
REQ-030 While reset=1: state=IDLE, last_grant=DMA (core wins the first tie), all registered we/addr/wdata=0, mem_we=0, busy=0, both acks=0, both rdata=0.
REQ-031 Reset asserted in ACCESS or RESP aborts the access immediately (asynchronous): mem_we drops in the same cycle, and no ack is issued for the aborted access.

Verification
REQ-032 Core-only write: core_req=1, we=1, addr=0x10, wdata=0x12345678 -> mem_we=1 with addr 0x10 in ACCESS; core_ack pulses 2 cycles after the request; dma_ack stays 0.
REQ-033 DMA read after write: dma reads addr 0x10 -> dma_ack pulses with dma_rdata=0x12345678; core_rdata=0 throughout.
REQ-034 Simultaneous requests after reset: both req=1 -> core is granted first, DMA second; acks are 3 cycles apart; grants alternate over 6 accesses.
REQ-035 Back-to-back: core_req held high for 4 accesses with no DMA -> core_ack pulses every 3 cycles; busy=0 for exactly one cycle between accesses.
REQ-036 Reset mid-ACCESS of a write to addr 0x20 -> mem_we falls immediately; no ack issued; busy=0; the next access completes normally.
REQ-037 Write data 0x0000FF00 then 0x00FF0000 to the same address, then a read -> read returns 0x00FF0000.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving the core and a DMA engine shared access
// to a single-port data memory; one access every three cycles.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              last_grant;
    logic              grant_dma;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              take;
    logic              pick_dma;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        pick_dma  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        core_ack  = 1'b0;
        dma_ack   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (core_req || dma_req) begin
                    take = 1'b1;
                    // DMA wins a tie only when the core was granted last
                    pick_dma = dma_req && (!core_req || !last_grant);
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_we    = we_q;
                state_nxt = RESP;
            end
            RESP: begin
                core_ack  = !grant_dma;
                dma_ack   = grant_dma;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant_dma  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (take) begin
            last_grant <= pick_dma;
            grant_dma  <= pick_dma;
            we_q       <= pick_dma ? dma_we : core_we;
            addr_q     <= pick_dma ? dma_addr : core_addr;
            wdata_q    <= pick_dma ? dma_wdata : core_wdata;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign core_rdata = (core_ack && !we_q) ? mem_rdata : '0;
    assign dma_rdata  = (dma_ack && !we_q) ? mem_rdata : '0;

endmodule
